// File: rtl/inst_encoder_pkg.sv
// Shared encodings for the instruction encoder: bundle kinds, MIPS opcodes,
// the packer's field bundle and the loader FSM states.
package inst_encoder_pkg;

    localparam int W_KIND = 3;

    localparam logic [W_KIND-1:0] K_R   = 3'd0;
    localparam logic [W_KIND-1:0] K_I   = 3'd1;
    localparam logic [W_KIND-1:0] K_J   = 3'd2;
    localparam logic [W_KIND-1:0] K_LI  = 3'd3;
    localparam logic [W_KIND-1:0] K_END = 3'd4;

    localparam logic [5:0] OP_ZERO = 6'h00;
    localparam logic [5:0] ADDI    = 6'h08;
    localparam logic [5:0] ORI     = 6'h0d;
    localparam logic [5:0] LUI     = 6'h0f;

    typedef struct packed {
        logic [W_KIND-1:0] kind;
        logic [5:0]        op;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        sha;
        logic [15:0]       imm;
        logic [25:0]       addr;
    } fields_t;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LI2  = 2'd1,
        S_DONE = 2'd2,
        S_FULL = 2'd3
    } state_t;

endpackage

// File: rtl/inst_encoder_pack.sv
// Packs one R/I/J field bundle into a 32-bit MIPS word; purely combinational.
// No handshake of its own; any other kind packs to zero.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (f.kind)
            K_R:     word = {OP_ZERO, f.rs, f.rt, f.rd, f.sha, f.funct};
            K_I:     word = {f.op, f.rs, f.rt, f.imm};
            K_J:     word = {f.op, f.addr};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder: writes one packed word per accepted bundle, LI may take two.
// Registered write one cycle after acceptance; in_ready drops in S_LI2, S_DONE, S_FULL or when memory is full.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int                W_ADDR    = 10,
    parameter logic [W_ADDR-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [5:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_sha,
    input  logic [31:0]       in_imm,
    input  logic [25:0]       in_addr,
    output logic              mem_wen,
    output logic [W_ADDR-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [W_ADDR:0]   count,
    output logic              done,
    output logic              overflow
);

    localparam logic [W_ADDR:0] DEPTH = {1'b1, {W_ADDR{1'b0}}};
    localparam logic [W_ADDR:0] ONE   = {{W_ADDR{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [W_ADDR-1:0] wptr;
    logic [W_ADDR:0]   free;
    logic [4:0]        li_rt;
    logic [15:0]       li_lo;
    logic              xfer, li_two, li_short;
    logic              do_write, set_done, set_ovf;
    fields_t           pf;
    logic [31:0]       word;

    assign free     = DEPTH - count;
    assign in_ready = (state == S_RUN) && (free != '0);
    assign xfer     = in_valid & in_ready;
    assign li_two   = (in_imm[31:16] != '0) && (in_imm[15:0] != '0);
    // Two-word LI is refused whole rather than writing a lone LUI into the last slot.
    assign li_short = li_two && (free == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (xfer) begin
                    if (in_kind == K_END)
                        state_nxt = S_DONE;
                    else if (in_kind == K_LI && li_two)
                        state_nxt = li_short ? S_FULL : S_LI2;
                end else if (in_valid && free == '0) begin
                    state_nxt = S_FULL;
                end
            end
            S_LI2:   state_nxt = S_RUN;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        do_write = 1'b0;
        set_done = 1'b0;
        set_ovf  = 1'b0;
        case (state)
            S_RUN: begin
                if (xfer) begin
                    case (in_kind)
                        K_R, K_I, K_J: do_write = 1'b1;
                        K_LI: begin
                            do_write = !li_short;
                            set_ovf  = li_short;
                        end
                        K_END:   set_done = 1'b1;
                        default: ;
                    endcase
                end else if (in_valid && free == '0) begin
                    set_ovf = 1'b1;
                end
            end
            S_LI2:   do_write = 1'b1;
            default: ;
        endcase
    end

    // LI is re-expressed as an I-kind bundle so a single packer serves every word.
    always_comb begin
        pf = '{kind: in_kind, op: in_op, funct: in_funct, rs: in_rs, rt: in_rt,
               rd: in_rd, sha: in_sha, imm: in_imm[15:0], addr: in_addr};
        if (state == S_LI2) begin
            pf.kind = K_I;
            pf.op   = ORI;
            pf.rs   = li_rt;
            pf.rt   = li_rt;
            pf.imm  = li_lo;
        end else if (in_kind == K_LI) begin
            pf.kind = K_I;
            pf.rs   = '0;
            if (in_imm[31:16] == '0) begin
                pf.op  = ORI;
                pf.imm = in_imm[15:0];
            end else begin
                pf.op  = LUI;
                pf.imm = in_imm[31:16];
            end
        end
    end

    inst_pack u_pack (
        .f    (pf),
        .word (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            wptr      <= BASE_ADDR;
            li_rt     <= '0;
            li_lo     <= '0;
        end else begin
            mem_wen <= do_write;
            if (do_write) begin
                mem_waddr <= wptr;
                mem_wdata <= word;
                wptr      <= wptr + 1'b1;
                count     <= count + 1'b1;
            end
            if (set_done) done     <= 1'b1;
            if (set_ovf)  overflow <= 1'b1;
            if (state == S_RUN && xfer && in_kind == K_LI) begin
                li_rt <= in_rt;
                li_lo <= in_imm[15:0];
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed spec cases plus random episodes against a
// transaction-level model of expected memory writes and sticky flags.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int WA    = 2;
    localparam int DEPTH = 4;
    localparam int BASE  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_kind = '0;
    logic [5:0]    in_op = '0, in_funct = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_sha = '0;
    logic [31:0]   in_imm = '0;
    logic [25:0]   in_addr = '0;
    logic          mem_wen;
    logic [WA-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [WA:0]   count;
    logic          done, overflow;

    inst_encoder #(.W_ADDR(WA), .BASE_ADDR(2'(BASE))) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_sha(in_sha), .in_imm(in_imm),
        .in_addr(in_addr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .count(count), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    int          mcount;
    bit          mdone, mfull, li2_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the oldest word the model still expects.
    always @(negedge clk) begin
        if (rst_n && mem_wen) begin
            if (exp_q.size() == 0) begin
                check("spurious_wen", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", 32'(mem_waddr), mon_e[63:32]);
                check("wdata", mem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic do_reset();
        in_valid    = 1'b0;
        rst_n       = 1'b0;
        exp_q.delete();
        mcount      = 0;
        mdone       = 0;
        mfull       = 0;
        li2_pending = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] i_word(input int op, input int rs, input int rt, input int imm16);
        return 32'((op << 26) | (rs << 21) | (rt << 16) | (imm16 & 'hffff));
    endfunction

    task automatic send(input logic [2:0] k, input logic [5:0] op, input logic [5:0] funct,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sha, input logic [31:0] imm, input logic [25:0] addr);
        bit          exp_rdy;
        logic [31:0] w[$];
        int          hi, lo;
        if (li2_pending) begin
            @(negedge clk);
            check("li2_ready", 32'(in_ready), 32'd0);
            li2_pending = 0;
        end
        @(negedge clk);
        in_kind = k; in_op = op; in_funct = funct; in_rs = rs; in_rt = rt;
        in_rd = rd; in_sha = sha; in_imm = imm; in_addr = addr; in_valid = 1'b1;
        #1;
        exp_rdy = !mdone && !mfull && (mcount < DEPTH);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            hi = int'(imm >> 16);
            lo = int'(imm & 32'hffff);
            case (k)
                K_R: w.push_back(32'((int'(rs) << 21) | (int'(rt) << 16) | (int'(rd) << 11)
                                     | (int'(sha) << 6) | int'(funct)));
                K_I: w.push_back(i_word(int'(op), int'(rs), int'(rt), lo));
                K_J: w.push_back(32'((int'(op) << 26) | int'(addr)));
                K_LI: begin
                    if (hi == 0)       w.push_back(i_word(13, 0, int'(rt), lo));
                    else if (lo == 0)  w.push_back(i_word(15, 0, int'(rt), hi));
                    else if (DEPTH - mcount < 2) mfull = 1;
                    else begin
                        w.push_back(i_word(15, 0, int'(rt), hi));
                        w.push_back(i_word(13, int'(rt), int'(rt), lo));
                        li2_pending = 1;
                    end
                end
                K_END:   mdone = 1;
                default: ;
            endcase
            foreach (w[i]) begin
                exp_q.push_back({32'((BASE + mcount) % DEPTH), w[i]});
                mcount++;
            end
        end else if (!mdone && !mfull) begin
            mfull = 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic end_check();
        repeat (3) @(negedge clk);
        li2_pending = 0;
        check("count", 32'(count), 32'(mcount));
        check("done", 32'(done), 32'(mdone));
        check("overflow", 32'(overflow), 32'(mfull));
        check("in_ready_idle", 32'(in_ready), 32'(!mdone && !mfull && mcount < DEPTH));
        check("pending_words", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        send(K_R, 6'd0, 6'h20, rs, rt, rd, 5'd0, 32'd0, 26'd0);
    endtask

    task automatic send_li(input logic [4:0] rt, input logic [31:0] imm);
        send(K_LI, 6'd0, 6'd0, 5'd0, rt, 5'd0, 5'd0, imm, 26'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  k;
        logic [31:0] imm;
        int          r, n;

        // Reset values and basic R/I/J packing
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", {30'd0, done, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_r(5'd1, 5'd2, 5'd3);
        check("add_wen", 32'(mem_wen), 32'd1);
        check("add_waddr", 32'(mem_waddr), 32'(BASE));
        check("add_wdata", mem_wdata, 32'h00221820);
        send(K_I, ADDI, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000ffff, 26'd0);
        check("addi_wdata", mem_wdata, 32'h2008ffff);
        send(K_J, 6'd2, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h0100000);
        check("j_wdata", mem_wdata, 32'h08100000);
        end_check();

        // LI forms filling the memory, then one bundle too many
        do_reset();
        send_li(5'd9, 32'h12345678);
        check("li_lui", mem_wdata, 32'h3c091234);
        send_li(5'd9, 32'h0000beef);
        check("li_ori_only", mem_wdata, 32'h3409beef);
        send_li(5'd9, 32'h00010000);
        check("li_lui_only", mem_wdata, 32'h3c090001);
        end_check();
        check("full_count", 32'(count), 32'd4);
        send_r(5'd4, 5'd5, 5'd6);
        check("full_no_wen", 32'(mem_wen), 32'd0);
        check("full_ovf", 32'(overflow), 32'd1);
        end_check();

        // Two-word LI with a single free slot
        do_reset();
        repeat (3) send_r(5'd1, 5'd1, 5'd1);
        send_li(5'd9, 32'h12345678);
        check("li_short_no_wen", 32'(mem_wen), 32'd0);
        check("li_short_ovf", 32'(overflow), 32'd1);
        end_check();

        // End marker
        do_reset();
        send(K_END, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
        check("end_done", 32'(done), 32'd1);
        check("end_ready", 32'(in_ready), 32'd0);
        end_check();

        // Reset between the LUI and ORI halves
        do_reset();
        send_li(5'd9, 32'h12345678);
        check("mid_lui", mem_wdata, 32'h3c091234);
        @(negedge clk);
        check("mid_li2_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        mcount = 0;
        li2_pending = 0;
        #1;
        check("mid_rst_wen", 32'(mem_wen), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_no_ori", 32'(mem_wen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_r(5'd7, 5'd8, 5'd9);
        check("after_rst_waddr", 32'(mem_waddr), 32'(BASE));
        end_check();

        // Random episodes
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            n = $urandom_range(1, 7);
            for (int t = 0; t < n; t++) begin
                r = $urandom_range(0, 15);
                if (r < 4)       k = K_R;
                else if (r < 7)  k = K_I;
                else if (r < 9)  k = K_J;
                else if (r < 13) k = K_LI;
                else if (r < 14) k = K_END;
                else             k = 3'($urandom_range(5, 7));
                imm = $urandom;
                case ($urandom_range(0, 3))
                    0: imm = imm & 32'h0000ffff;
                    1: imm = imm & 32'hffff0000;
                    default: ;
                endcase
                send(k, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 5'($urandom), imm, 26'($urandom));
            end
            end_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
